// File: rtl/mpu_sequencer.sv
`default_nettype none
// ============================================================================
// mpu_sequencer : fetch / execute / store controller for the matrix unit
// Rev 1.0
// ============================================================================
module mpu_sequencer #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int DIM           = 5,
  parameter int ADDR_WIDTH    = 8,
  parameter int EXEC_LATENCY  = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [2:0]                        cmd_operation,
  input  logic [ADDR_WIDTH-1:0]             cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0]             cmd_addr_b,
  input  logic [ADDR_WIDTH-1:0]             cmd_addr_r,
  input  logic [7:0]                        cmd_size,
  input  logic [7:0]                        cmd_factor,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic                              mem_read,
  input  logic [ELEMENT_WIDTH-1:0]          mem_rdata,
  output logic                              mem_write,
  output logic [ELEMENT_WIDTH-1:0]          mem_wdata,
  output logic [2:0]                        mpu_operation,
  output logic [DIM*DIM*ELEMENT_WIDTH-1:0]  mpu_matrix_a,
  output logic [DIM*DIM*ELEMENT_WIDTH-1:0]  mpu_matrix_b,
  output logic [7:0]                        mpu_size,
  output logic [7:0]                        mpu_factor,
  input  logic [DIM*DIM*ELEMENT_WIDTH-1:0]  mpu_result,
  input  logic [ELEMENT_WIDTH-1:0]          mpu_determinant,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int NUM = DIM * DIM;
  localparam int MW  = NUM * ELEMENT_WIDTH;
  localparam int CW  = $clog2(NUM + EXEC_LATENCY + 2);

  localparam logic [CW-1:0] C_FETCH_LAST = CW'(NUM);
  localparam logic [CW-1:0] C_EXEC_LAST  = CW'(EXEC_LATENCY);
  localparam logic [CW-1:0] C_STORE_LAST = CW'(NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_B = 3'd2,
    S_EXECUTE = 3'd3,
    S_STORE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              op_q;
  logic [7:0]              size_q, factor_q;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_b_q, addr_r_q;
  logic [MW-1:0]           a_q, b_q, res_q;
  logic                    error_q;

  logic                    cmd_illegal;
  logic                    needs_b;
  logic                    is_fetch;
  logic [CW-1:0]           cap_idx;
  logic [CW-1:0]           store_last;
  logic [ADDR_WIDTH-1:0]   fetch_base;
  logic [ELEMENT_WIDTH-1:0] store_elem;

  assign cmd_illegal = (cmd_operation == 3'd7) || (cmd_size == 8'd0) || (cmd_size > 8'(DIM));
  assign needs_b     = (op_q == 3'd0) || (op_q == 3'd1) || (op_q == 3'd6);
  assign is_fetch    = (state_q == S_FETCH_A) || (state_q == S_FETCH_B);
  // Read data lags the strobe by one cycle, so counter k lands element k-1.
  assign cap_idx     = cnt_q - CW'(1);
  assign store_last  = (op_q == 3'd5) ? '0 : C_STORE_LAST;
  assign fetch_base  = (state_q == S_FETCH_A) ? addr_a_q : addr_b_q;

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign error         = error_q;
  assign mpu_operation = op_q;
  assign mpu_size      = size_q;
  assign mpu_factor    = factor_q;
  assign mpu_matrix_a  = a_q;
  assign mpu_matrix_b  = b_q;

  always_comb begin
    store_elem = '0;
    for (int i = 0; i < NUM; i++) begin
      if (cnt_q == CW'(i)) store_elem = res_q[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = cmd_illegal ? S_DONE : S_FETCH_A;
          cnt_d   = '0;
        end
      end
      S_FETCH_A, S_FETCH_B: begin
        if (cnt_q < C_FETCH_LAST) begin
          mem_read = 1'b1;
          mem_addr = fetch_base + ADDR_WIDTH'(cnt_q);
        end
        if (cnt_q == C_FETCH_LAST) begin
          cnt_d   = '0;
          state_d = ((state_q == S_FETCH_A) && needs_b) ? S_FETCH_B : S_EXECUTE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXECUTE: begin
        if (cnt_q == C_EXEC_LAST) begin
          cnt_d   = '0;
          state_d = S_STORE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STORE: begin
        mem_write = 1'b1;
        mem_addr  = addr_r_q + ADDR_WIDTH'(cnt_q);
        mem_wdata = store_elem;
        if (cnt_q == store_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      size_q   <= '0;
      factor_q <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_r_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && cmd_valid) begin
        op_q     <= cmd_operation;
        size_q   <= cmd_size;
        factor_q <= cmd_factor;
        addr_a_q <= cmd_addr_a;
        addr_b_q <= cmd_addr_b;
        addr_r_q <= cmd_addr_r;
      end
      if (is_fetch && (cnt_q != '0)) begin
        for (int i = 0; i < NUM; i++) begin
          if (cap_idx == CW'(i)) begin
            if (state_q == S_FETCH_A) a_q[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= mem_rdata;
            else                      b_q[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= mem_rdata;
          end
        end
      end
      if ((state_q == S_EXECUTE) && (cnt_q == C_EXEC_LAST)) begin
        res_q <= (op_q == 3'd5) ? {{(MW-ELEMENT_WIDTH){1'b0}}, mpu_determinant} : mpu_result;
      end
      // Only the IDLE->DONE shortcut is a rejection; error then holds until the next done.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        error_q <= (state_q == S_IDLE);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpu_sequencer.sv
`default_nettype none
// Testbench for mpu_sequencer: memory model, stand-in datapath, reference model.
module tb_mpu_sequencer;
  localparam int EW  = 8;
  localparam int D   = 5;
  localparam int N   = D * D;
  localparam int AW  = 8;
  localparam int EXL = 1;
  localparam int MW  = N * EW;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_operation;
  logic [AW-1:0] cmd_addr_a, cmd_addr_b, cmd_addr_r;
  logic [7:0]    cmd_size, cmd_factor;
  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_write;
  logic [EW-1:0] mem_rdata, mem_wdata;
  logic [2:0]    mpu_operation;
  logic [MW-1:0] mpu_matrix_a, mpu_matrix_b, mpu_result;
  logic [7:0]    mpu_size, mpu_factor;
  logic [EW-1:0] mpu_determinant;
  logic          busy, done, error;

  always #5 clock = ~clock;

  mpu_sequencer #(.ELEMENT_WIDTH(EW), .DIM(D), .ADDR_WIDTH(AW), .EXEC_LATENCY(EXL)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_operation(cmd_operation),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_r(cmd_addr_r),
    .cmd_size(cmd_size), .cmd_factor(cmd_factor),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mpu_operation(mpu_operation), .mpu_matrix_a(mpu_matrix_a), .mpu_matrix_b(mpu_matrix_b),
    .mpu_size(mpu_size), .mpu_factor(mpu_factor),
    .mpu_result(mpu_result), .mpu_determinant(mpu_determinant),
    .busy(busy), .done(done), .error(error)
  );

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  logic [7:0] rd_addrs [$];
  int n_reads, n_writes, n_accepts, n_overlap;
  int checks = 0, errors = 0;
  int exp_lat, exp_reads, exp_writes;
  bit exp_err;

  // Element-wise matrix semantics; the transpose/multiply only cover the active size.
  function automatic logic [7:0] calc(input logic [2:0] op, input logic [MW-1:0] a,
                                      input logic [MW-1:0] b, input int size,
                                      input logic [7:0] f, input int i);
    int r, c, acc;
    r = i / D;
    c = i % D;
    acc = 0;
    case (op)
      3'd0: acc = $signed(a[i*EW +: EW]) + $signed(b[i*EW +: EW]);
      3'd1: acc = $signed(a[i*EW +: EW]) - $signed(b[i*EW +: EW]);
      3'd2: acc = $signed(a[i*EW +: EW]) * $signed(f);
      3'd3: acc = -$signed(a[i*EW +: EW]);
      3'd4: if (r < size && c < size) acc = int'(a[(c*D+r)*EW +: EW]);
      3'd6: if (r < size && c < size)
              for (int k = 0; k < size; k++)
                acc += $signed(a[(r*D+k)*EW +: EW]) * $signed(b[(k*D+c)*EW +: EW]);
      default: acc = 0;
    endcase
    return acc[7:0];
  endfunction

  // Stand-in determinant: product of the diagonal (exact for triangular inputs).
  function automatic logic [7:0] det_stub(input logic [MW-1:0] a, input int size);
    int acc;
    acc = 1;
    for (int k = 0; k < size; k++) acc = acc * $signed(a[(k*D+k)*EW +: EW]);
    return acc[7:0];
  endfunction

  always_comb begin
    mpu_result = '0;
    for (int i = 0; i < N; i++)
      mpu_result[i*EW +: EW] = calc(mpu_operation, mpu_matrix_a, mpu_matrix_b,
                                    int'(mpu_size), mpu_factor, i);
    mpu_determinant = det_stub(mpu_matrix_a, int'(mpu_size));
  end

  task automatic monitor();
    forever begin
      @(posedge clock);
      if (mem_read) begin
        mem_rdata <= mem[mem_addr];
        n_reads++;
        rd_addrs.push_back(mem_addr);
      end
      if (mem_write) begin
        mem[mem_addr] = mem_wdata;
        n_writes++;
      end
      if (mem_read && mem_write) n_overlap++;
      if (cmd_valid && cmd_ready) n_accepts++;
    end
  endtask

  function automatic int mem_diff();
    int bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) bad++;
    return bad;
  endfunction

  // Reference: expected memory image, latency and strobe counts from the command alone.
  task automatic ref_expect(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] r, input logic [7:0] sz, input logic [7:0] f);
    logic [MW-1:0] pa, pb;
    bit two;
    for (int k = 0; k < 256; k++) exp_mem[k] = mem[k];
    for (int i = 0; i < N; i++) begin
      pa[i*EW +: EW] = mem[(int'(a) + i) % 256];
      pb[i*EW +: EW] = mem[(int'(b) + i) % 256];
    end
    exp_err = (op == 3'd7) || (sz == 8'd0) || (sz > 8'(D));
    two = (op == 3'd0) || (op == 3'd1) || (op == 3'd6);
    if (exp_err) begin
      exp_lat = 1; exp_reads = 0; exp_writes = 0;
    end else if (op == 3'd5) begin
      exp_mem[r] = det_stub(pa, int'(sz));
      exp_lat = 1 + (N + 1) + (EXL + 1) + 1; exp_reads = N; exp_writes = 1;
    end else begin
      for (int i = 0; i < N; i++) exp_mem[(int'(r) + i) % 256] = calc(op, pa, pb, int'(sz), f, i);
      exp_lat    = 1 + (two ? 2 : 1) * (N + 1) + (EXL + 1) + N;
      exp_reads  = two ? 2 * N : N;
      exp_writes = N;
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic [7:0] sz, input logic [7:0] f,
                         input bit hold, output int lat, output logic err);
    n_reads = 0; n_writes = 0; n_accepts = 0;
    rd_addrs.delete();
    @(negedge clock);
    cmd_operation = op; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_r = r;
    cmd_size = sz; cmd_factor = f; cmd_valid = 1'b1;
    lat = 0;
    while (!cmd_ready && lat < 200) begin @(negedge clock); lat++; end
    @(negedge clock);
    lat = 1;
    if (!hold) cmd_valid = 1'b0;
    while (!done && lat < 200) begin @(negedge clock); lat++; end
    err = error;
    cmd_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_status: busy/done/error %b%b%b expected 000", busy, done, error); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL reset_mem: rd %b wr %b addr %h expected 0", mem_read, mem_write, mem_addr); end
    checks++; if (mpu_matrix_a !== '0 || mpu_matrix_b !== '0) begin errors++; $display("FAIL reset_operands: nonzero operand, expected 0"); end
    checks++; if (mpu_operation !== 3'd0 || mpu_size !== 8'd0 || mpu_factor !== 8'd0) begin errors++; $display("FAIL reset_mpu: op %0d size %0d factor %0d expected 0", mpu_operation, mpu_size, mpu_factor); end
  endtask

  task automatic test_add();
    int lat; logic err;
    for (int i = 0; i < N; i++) begin mem[i] = 8'(i); mem[8'h40 + i] = 8'd1; end
    run_cmd(3'd0, 8'h00, 8'h40, 8'h80, 8'd5, 8'd0, 1'b0, lat, err);
    checks++; if (lat !== 80) begin errors++; $display("FAIL add_latency: got %0d expected 80", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_error: got %b expected 0", err); end
    checks++; if (n_reads !== 2*N || n_writes !== N) begin errors++; $display("FAIL add_strobes: reads %0d writes %0d expected %0d %0d", n_reads, n_writes, 2*N, N); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[8'h80 + i] !== 8'(i + 1)) begin errors++; $display("FAIL add_elem%0d: got %0d expected %0d", i, mem[8'h80 + i], i + 1); end
    end
  endtask

  task automatic test_scalar_mul();
    int lat, hits; logic err;
    for (int i = 0; i < N; i++) mem[8'h20 + i] = 8'(i - 12);
    run_cmd(3'd2, 8'h20, 8'h60, 8'hC0, 8'd5, 8'hFE, 1'b0, lat, err);
    hits = 0;
    foreach (rd_addrs[k]) if (rd_addrs[k] >= 8'h60 && rd_addrs[k] < 8'h60 + N) hits++;
    checks++; if (hits !== 0) begin errors++; $display("FAIL smul_b_reads: got %0d reads at addr_b expected 0", hits); end
    checks++; if (lat !== 54) begin errors++; $display("FAIL smul_latency: got %0d expected 54", lat); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[8'hC0 + i] !== 8'(24 - 2*i)) begin errors++; $display("FAIL smul_elem%0d: got %h expected %h", i, mem[8'hC0 + i], 8'(24 - 2*i)); end
    end
  endtask

  task automatic test_det();
    int lat; logic err;
    for (int i = 0; i < N; i++) mem[8'hA0 + i] = (i % (D + 1) == 0) ? 8'd1 : 8'd0;
    mem[8'h10] = 8'h33; mem[8'h11] = 8'h5A;
    run_cmd(3'd5, 8'hA0, 8'h00, 8'h10, 8'd5, 8'd0, 1'b0, lat, err);
    checks++; if (n_writes !== 1) begin errors++; $display("FAIL det_writes: got %0d expected 1", n_writes); end
    checks++; if (mem[8'h10] !== 8'd1) begin errors++; $display("FAIL det_value: got %0d expected 1", mem[8'h10]); end
    checks++; if (mem[8'h11] !== 8'h5A) begin errors++; $display("FAIL det_neighbour: got %h expected 5a", mem[8'h11]); end
    checks++; if (lat !== 30) begin errors++; $display("FAIL det_latency: got %0d expected 30", lat); end
  endtask

  task automatic test_illegal();
    logic [2:0] ops [3] = '{3'd7, 3'd0, 3'd0};
    logic [7:0] szs [3] = '{8'd5, 8'd0, 8'd6};
    int lat; logic err;
    for (int t = 0; t < 3; t++) begin
      run_cmd(ops[t], 8'h00, 8'h40, 8'h80, szs[t], 8'd0, 1'b0, lat, err);
      checks++; if (lat !== 1) begin errors++; $display("FAIL illegal%0d_latency: got %0d expected 1", t, lat); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal%0d_error: got %b expected 1", t, err); end
      checks++; if (n_reads + n_writes !== 0) begin errors++; $display("FAIL illegal%0d_strobes: got %0d expected 0", t, n_reads + n_writes); end
    end
  endtask

  task automatic test_wrap_backpressure();
    int lat; logic err;
    for (int i = 0; i < N; i++) mem[(8'hF0 + i) % 256] = 8'($urandom);
    ref_expect(3'd3, 8'hF0, 8'h00, 8'h30, 8'd5, 8'd0);
    run_cmd(3'd3, 8'hF0, 8'h00, 8'h30, 8'd5, 8'd0, 1'b1, lat, err);
    checks++; if (n_accepts !== 1) begin errors++; $display("FAIL bp_accepts: got %0d expected 1", n_accepts); end
    checks++;
    if (rd_addrs.size() !== N) begin errors++; $display("FAIL wrap_reads: got %0d reads expected %0d", rd_addrs.size(), N); end
    else if (rd_addrs[0] !== 8'hF0 || rd_addrs[N-1] !== 8'h08) begin errors++; $display("FAIL wrap_addrs: first %h last %h expected f0 08", rd_addrs[0], rd_addrs[N-1]); end
    checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL wrap_result: %0d bytes differ expected 0", mem_diff()); end
    checks++; if (lat !== 54) begin errors++; $display("FAIL wrap_latency: got %0d expected 54", lat); end
  endtask

  task automatic test_random();
    int lat; logic err;
    logic [2:0] op; logic [7:0] a, b, r, sz, f;
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      op = 3'($urandom_range(0, 7)); sz = 8'($urandom_range(0, 6));
      a = 8'($urandom); b = 8'($urandom); r = 8'($urandom); f = 8'($urandom);
      ref_expect(op, a, b, r, sz, f);
      run_cmd(op, a, b, r, sz, f, 1'b0, lat, err);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_latency: op %0d got %0d expected %0d", t, op, lat, exp_lat); end
      checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd%0d_error: got %b expected %b", t, err, exp_err); end
      checks++; if (n_reads !== exp_reads || n_writes !== exp_writes) begin errors++; $display("FAIL rnd%0d_strobes: r %0d w %0d expected %0d %0d", t, n_reads, n_writes, exp_reads, exp_writes); end
      checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL rnd%0d_memory: op %0d size %0d, %0d bytes differ", t, op, sz, mem_diff()); end
    end
    checks++; if (n_overlap !== 0) begin errors++; $display("FAIL rw_overlap: got %0d expected 0", n_overlap); end
  endtask

  task automatic test_reset_mid_store();
    int lat, guard; logic err;
    for (int i = 0; i < N; i++) begin mem[i] = 8'($urandom); mem[8'h40 + i] = 8'($urandom); end
    n_writes = 0;
    @(negedge clock);
    cmd_operation = 3'd0; cmd_addr_a = 8'h00; cmd_addr_b = 8'h40; cmd_addr_r = 8'h80;
    cmd_size = 8'd5; cmd_factor = 8'd0; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    guard = 0;
    while (n_writes < 10 && guard < 300) begin @(negedge clock); guard++; end
    checks++; if (n_writes !== 10) begin errors++; $display("FAIL rst_store_reach: got %0d writes expected 10", n_writes); end
    reset = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL rst_mem_outputs: wr %b rd %b addr %h expected 0", mem_write, mem_read, mem_addr); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_status: ready %b busy %b done %b expected 100", cmd_ready, busy, done); end
    checks++; if (mpu_matrix_a !== '0 || mpu_operation !== 3'd0) begin errors++; $display("FAIL rst_mpu: operands not cleared, op %0d", mpu_operation); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (n_writes !== 10) begin errors++; $display("FAIL rst_no_write: got %0d writes expected 10", n_writes); end
    for (int i = 0; i < N; i++) begin mem[i] = 8'($urandom); mem[8'h40 + i] = 8'($urandom); end
    ref_expect(3'd0, 8'h00, 8'h40, 8'h80, 8'd5, 8'd0);
    run_cmd(3'd0, 8'h00, 8'h40, 8'h80, 8'd5, 8'd0, 1'b0, lat, err);
    checks++; if (mem_diff() !== 0 || lat !== 80) begin errors++; $display("FAIL rst_recover: %0d bytes differ, latency %0d expected 0, 80", mem_diff(), lat); end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_operation = '0; cmd_addr_a = '0; cmd_addr_b = '0; cmd_addr_r = '0;
    cmd_size = '0; cmd_factor = '0; mem_rdata = '0;
    n_reads = 0; n_writes = 0; n_accepts = 0; n_overlap = 0;
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    fork monitor(); join_none
    test_reset();
    test_add();
    test_scalar_mul();
    test_det();
    test_illegal();
    test_wrap_backpressure();
    test_random();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mpu_sequencer.md
Name: mpu_sequencer

Overview:
- Command-driven controller that sequences the matrix processing unit datapath.
- Accepts one matrix command at a time over a valid/ready handshake.
- Fetches operand matrix A, and B when the op needs it, from element-wide memory, element by element.
- Drives the datapath for a fixed latency, then writes the result matrix (or the determinant) back to memory and pulses done.

Parameters:
ELEMENT_WIDTH, 8, bits per signed matrix element
DIM, 5, matrix dimension; matrices are DIM*DIM elements
ADDR_WIDTH, 8, memory address width
EXEC_LATENCY, 1, datapath clocks from stable operands to valid result

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  high only in IDLE
cmd_operation  input  3  0 add, 1 sub, 2 scalar mul, 3 opposite, 4 transpose, 5 det, 6 mul, 7 illegal
cmd_addr_a  input  ADDR_WIDTH  base address of A
cmd_addr_b  input  ADDR_WIDTH  base address of B
cmd_addr_r  input  ADDR_WIDTH  base address of result
cmd_size  input  8  active dimension, legal 1..DIM
cmd_factor  input  8  signed scalar for op 2
mem_addr  output  ADDR_WIDTH  memory address
mem_read  output  1  read strobe; mem_rdata is valid the next cycle
mem_rdata  input  ELEMENT_WIDTH  read data
mem_write  output  1  write strobe
mem_wdata  output  ELEMENT_WIDTH  write data
mpu_operation  output  3  latched op to datapath
mpu_matrix_a  output  DIM*DIM*ELEMENT_WIDTH  operand A
mpu_matrix_b  output  DIM*DIM*ELEMENT_WIDTH  operand B
mpu_size  output  8  latched size
mpu_factor  output  8  latched factor
mpu_result  input  DIM*DIM*ELEMENT_WIDTH  datapath matrix result
mpu_determinant  input  ELEMENT_WIDTH  datapath determinant
busy  output  1  high when not IDLE
done  output  1  one-cycle completion pulse
error  output  1  valid with done; 1 means the command was rejected

Behaviour:
- Reset (async, any state):
  - state returns to IDLE.
  - All outputs go to 0 except cmd_ready, which is 1.
  - Operand registers are cleared.
  - No write is issued after reset asserts; any partially stored result is abandoned.
- Element layout:
  - Element i = row*DIM+col occupies bits [i*ELEMENT_WIDTH +: ELEMENT_WIDTH].
  - Its memory address is base+i, modulo 2^ADDR_WIDTH (wrap allowed).
- IDLE:
  - A command is accepted when cmd_valid && cmd_ready. All cmd_* fields are latched.
  - Illegal op is cmd_operation==7 or cmd_size==0 or cmd_size>DIM. It goes to DONE with error=1 and makes no memory access.
  - Otherwise go to FETCH_A.
- FETCH_A: 26 cycles.
  - Cycles 0..24: mem_read=1, mem_addr=addr_a+k.
  - The rdata returned in the following cycle is written to element k of A.
  - Cycle 25 is drain only, with mem_read=0.
  - Next state is FETCH_B for ops 0, 1, 6; otherwise EXECUTE.
- FETCH_B: identical to FETCH_A using addr_b; next state EXECUTE.
- Full DIM*DIM fetch is always performed regardless of size. The datapath honours mpu_size.
- EXECUTE: mpu_* are held stable for EXEC_LATENCY+1 cycles. On the last cycle the controller captures mpu_result, or mpu_determinant for op 5.
- STORE:
  - One write per cycle, mem_write=1, mem_addr=addr_r+k, mem_wdata=element k.
  - Op 5 writes 1 element (the determinant at addr_r); all other ops write 25 elements.
- DONE: done=1 for exactly one cycle, then IDLE.
  - cmd_ready rises in the IDLE cycle that follows.
- Latency, acceptance edge to done, legal ops:
  - Ops 0, 1, 6: 1+26+26+(EXEC_LATENCY+1)+25 = 80 cycles with default parameters.
  - Ops 2, 3, 4: 54 cycles.
  - Op 5: 30 cycles.
  - Illegal op: done on the cycle after acceptance.
- cmd_valid while busy is ignored; commands are never queued.
- mem_read and mem_write are never high in the same cycle.
- error holds its value until the next done.
- mpu_operation/size/factor change only on acceptance; they hold stable through EXECUTE.

Test Plan:
- Add: A[i]=i at 0x00, B[i]=1 at 0x40, addr_r=0x80, size 5 -> mem[0x80+i]=i+1; done 80 cycles after acceptance; error=0.
- Scalar mul: A[i]=i-12, factor=-2 -> mem[r+i]=24-2i; no reads at addr_b; done at 54 cycles.
- Det: A=identity, op 5, addr_r=0x10 -> exactly one write, mem[0x10]=1; done at 30 cycles.
- Illegal: op 7, then separately size 0 and size 6 -> done+error next cycle; zero mem_read/mem_write strobes.
- Wrap and backpressure: addr_a=0xF0, cmd_valid held high during busy -> reads wrap to 0x00..0x08; exactly one command executes per acceptance.
- Reset mid-STORE after 10 writes -> outputs zero, no further writes, cmd_ready=1; a new add command completes correctly.
